// File: rtl/dm_responder_pkg.sv
// Shared definitions for the data-memory responder: lane masks, trace record layout, FSM states.
// Latency and backpressure: not applicable (definitions only).
package dm_responder_pkg;

  localparam logic [3:0] BE_WORD  = 4'b1111;
  localparam logic [3:0] BE_HALF0 = 4'b0011;
  localparam logic [3:0] BE_HALF1 = 4'b1100;
  localparam logic [3:0] BE_BYTE0 = 4'b0001;
  localparam logic [3:0] BE_BYTE1 = 4'b0010;
  localparam logic [3:0] BE_BYTE2 = 4'b0100;
  localparam logic [3:0] BE_BYTE3 = 4'b1000;

  localparam int TRACE_W = 100;

  typedef enum logic {
    DM_CLEAR = 1'b0,
    DM_RUN   = 1'b1
  } dm_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  byteen;
  } trace_rec_t;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/dm_responder_if.sv
// CPU data-port bus between the MEM stage (master) and the data-memory responder (slave).
// Latency: read data is combinational from address; backpressure: none, the port is always ready.
interface dm_responder_if;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_inst_addr;
  logic [31:0] m_data_rdata;

  modport master (
    output m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr,
    input  m_data_rdata
  );

  modport slave (
    input  m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr,
    output m_data_rdata
  );
endinterface

// File: rtl/dm_responder_trace_fifo.sv
// trace_fifo: first-word-fall-through FIFO with a registered head word.
// Latency: a push into an empty FIFO shows at the head one cycle later; backpressure: push is dropped when full unless a pop coincides.
module trace_fifo #(
  parameter int W     = 100,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head_dat
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [AW:0]   count;
  logic          push_ok, pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rd_nxt  = rd_ptr + AW'(1);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      head_dat <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_nxt;
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      // Head reloads from the incoming record when it becomes the only entry, else from the next slot.
      if (push_ok && (empty || (pop_ok && count == (AW+1)'(1)))) begin
        head_dat <= push_dat;
      end else if (pop_ok && count > (AW+1)'(1)) begin
        head_dat <= mem[rd_nxt];
      end
    end
  end
endmodule

// File: rtl/dm_responder.sv
// dm_responder: byte-writable word RAM with a post-reset clear sweep and optional store trace FIFO (DM_TRACE_EN).
// Latency: reads combinational, writes visible after the edge; backpressure: trace_ready low fills the FIFO, overflow counts in trace_drop.
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int          ADDR_W      = 12,
  parameter logic [31:0] BASE        = 32'h0000_0000,
  parameter int          TRACE_DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  dm_responder_if.slave bus,
  output logic         init_done,
  output logic         oor_err,
  output logic         trace_valid,
  input  logic         trace_ready,
  output logic [31:0]  trace_pc,
  output logic [31:0]  trace_addr,
  output logic [31:0]  trace_data,
  output logic [3:0]   trace_byteen,
  output logic [15:0]  trace_drop
);
  localparam int DEPTH = 2**ADDR_W;

  dm_state_t         state;
  logic [ADDR_W-1:0] cnt, idx;
  logic [31:0]       offs, cur_word, new_word;
  logic              in_range, wr_en, wr_ok;
  logic [31:0]       ram [DEPTH];
  logic              unused_offs;

  assign offs        = bus.m_data_addr - BASE;
  assign idx         = offs[ADDR_W+1:2];
  assign in_range    = (bus.m_data_addr >= BASE) && (offs[31:ADDR_W+2] == '0);
  assign wr_en       = (state == DM_RUN) && (bus.m_data_byteen != 4'b0000);
  assign wr_ok       = wr_en && in_range;
  assign cur_word    = ram[idx];
  assign new_word    = merge_lanes(cur_word, bus.m_data_wdata, bus.m_data_byteen);
  assign bus.m_data_rdata = ((state == DM_RUN) && in_range) ? cur_word : '0;
  assign init_done   = (state == DM_RUN);
  assign unused_offs = ^offs[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= DM_CLEAR;
      cnt     <= '0;
      oor_err <= 1'b0;
    end else if (state == DM_CLEAR) begin
      cnt <= cnt + ADDR_W'(1);
      if (&cnt) state <= DM_RUN;
    end else if (wr_en && !in_range) begin
      oor_err <= 1'b1;
    end
  end

  // RAM carries no reset; the sweep zeroes it one word per cycle instead.
  always_ff @(posedge clk) begin
    if (state == DM_CLEAR) begin
      ram[cnt] <= '0;
    end else if (wr_ok) begin
      ram[idx] <= new_word;
    end
  end

`ifdef DM_TRACE_EN
  trace_rec_t push_rec, head_rec;
  logic       fifo_full, fifo_empty, pop;

  assign push_rec = '{pc:     bus.m_inst_addr,
                      addr:   {bus.m_data_addr[31:2], 2'b00},
                      data:   new_word,
                      byteen: bus.m_data_byteen};

  trace_fifo #(
    .W     (TRACE_W),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .push     (wr_ok),
    .push_dat (push_rec),
    .pop      (trace_ready),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head_dat (head_rec)
  );

  assign trace_valid  = !fifo_empty;
  assign pop          = trace_valid && trace_ready;
  assign trace_pc     = head_rec.pc;
  assign trace_addr   = head_rec.addr;
  assign trace_data   = head_rec.data;
  assign trace_byteen = head_rec.byteen;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trace_drop <= '0;
    end else if (wr_ok && fifo_full && !pop && (trace_drop != 16'hFFFF)) begin
      trace_drop <= trace_drop + 16'd1;
    end
  end
`else
  logic unused_trace;

  assign trace_valid  = 1'b0;
  assign trace_pc     = '0;
  assign trace_addr   = '0;
  assign trace_data   = '0;
  assign trace_byteen = '0;
  assign trace_drop   = '0;
  assign unused_trace = ^{trace_ready, bus.m_inst_addr};
`endif
endmodule

// File: tb/tb_dm_responder.sv
// Randomized bench for dm_responder against a queue/array reference model of memory, trace FIFO and error flag.
module tb_dm_responder;
  localparam int          ADDR_W = 4;
  localparam int          NW     = 16;
  localparam logic [31:0] BASE   = 32'h0000_0100;
  localparam int          TDEPTH = 8;
`ifdef DM_TRACE_EN
  localparam bit TRACE_EN = 1'b1;
`else
  localparam bit TRACE_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        init_done, oor_err, trace_valid, trace_ready;
  logic [31:0] trace_pc, trace_addr, trace_data;
  logic [3:0]  trace_byteen;
  logic [15:0] trace_drop;

  always #5 clk = ~clk;

  dm_responder_if bus ();

  dm_responder #(
    .ADDR_W      (ADDR_W),
    .BASE        (BASE),
    .TRACE_DEPTH (TDEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .init_done    (init_done),
    .oor_err      (oor_err),
    .trace_valid  (trace_valid),
    .trace_ready  (trace_ready),
    .trace_pc     (trace_pc),
    .trace_addr   (trace_addr),
    .trace_data   (trace_data),
    .trace_byteen (trace_byteen),
    .trace_drop   (trace_drop)
  );

  // Reference model state
  logic [31:0] mem_m [NW];
  rec_t        q[$];
  int          drop_m;
  bit          oor_m;
  bit          nopush;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < 32'(NW * 4));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NW; i++) mem_m[i] = '0;
    q.delete();
    drop_m = 0;
    oor_m  = 1'b0;
    nopush = 1'b1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] w, input logic [3:0] be,
                       input logic [31:0] pc, input logic rdy);
    bus.m_data_addr   = a;
    bus.m_data_wdata  = w;
    bus.m_data_byteen = be;
    bus.m_inst_addr   = pc;
    trace_ready       = rdy;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_init"},  init_done,         0);
    check_eq({tag, "_oor"},   oor_err,           0);
    check_eq({tag, "_vld"},   trace_valid,       0);
    check_eq({tag, "_pc"},    trace_pc,          0);
    check_eq({tag, "_addr"},  trace_addr,        0);
    check_eq({tag, "_data"},  trace_data,        0);
    check_eq({tag, "_be"},    trace_byteen,      0);
    check_eq({tag, "_drop"},  trace_drop,        0);
    check_eq({tag, "_rdata"}, bus.m_data_rdata,  0);
  endtask

  task automatic check_outputs();
    check_eq("init_done", init_done, 1);
    check_eq("oor_err", oor_err, oor_m);
    check_eq("trace_valid", trace_valid, q.size() > 0);
    check_eq("trace_drop", trace_drop, drop_m);
    if (q.size() > 0) begin
      check_eq("head_pc",   trace_pc,     q[0].pc);
      check_eq("head_addr", trace_addr,   q[0].addr);
      check_eq("head_data", trace_data,   q[0].data);
      check_eq("head_be",   trace_byteen, q[0].be);
    end else if (nopush) begin
      check_eq("idle_pc",   trace_pc,     0);
      check_eq("idle_data", trace_data,   0);
    end
  endtask

  // One RUN-state cycle: check the combinational read, clock, update the model, check registered outputs.
  task automatic step();
    logic [31:0] a, w, exp_rd;
    logic [3:0]  be;
    bit          pop, full;
    int          idx;
    rec_t        r;
    a  = bus.m_data_addr;
    w  = bus.m_data_wdata;
    be = bus.m_data_byteen;
    #1;
    exp_rd = in_rng(a) ? mem_m[int'((a - BASE) >> 2)] : 32'h0;
    check_eq("rdata", bus.m_data_rdata, exp_rd);
    @(posedge clk);
    full = (q.size() == TDEPTH);
    pop  = TRACE_EN && (q.size() > 0) && trace_ready;
    if (pop) void'(q.pop_front());
    if (be != 4'b0000) begin
      if (in_rng(a)) begin
        idx = int'((a - BASE) >> 2);
        for (int b = 0; b < 4; b++) if (be[b]) mem_m[idx][8*b +: 8] = w[8*b +: 8];
        r = '{pc: bus.m_inst_addr, addr: {a[31:2], 2'b00}, data: mem_m[idx], be: be};
        if (TRACE_EN) begin
          if (!full || pop) begin
            q.push_back(r);
            nopush = 1'b0;
          end else if (drop_m < 65535) begin
            drop_m++;
          end
        end
      end else begin
        oor_m = 1'b1;
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic wait_init();
    int edges;
    edges = 0;
    for (int k = 1; k <= 40 && edges == 0; k++) begin
      @(posedge clk);
      #1;
      if (init_done) edges = k;
      else if (k == 8) check_eq("sweep_rdata", bus.m_data_rdata, 0);
    end
    check_eq("init_edges", edges, 16);
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    drive(BASE + 8, 0, 0, 0, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b1;
    wait_init();

    for (int i = 0; i < NW; i++) begin
      drive(BASE + 32'(4 * i), 0, 0, 0, 0);
      step();
    end

    // Full-word store then single-lane merge
    drive(BASE + 8, 32'h1234_5678, 4'b1111, 32'h400, 0); step();
    drive(BASE + 8, 32'hAABB_CCDD, 4'b0100, 32'h404, 0); step();
    drive(BASE + 8, 0, 0, 0, 0);
    #1 check_eq("merge_rd", bus.m_data_rdata, 32'h12BB_5678);
    check_eq("rec0_data", trace_data, TRACE_EN ? 32'h1234_5678 : 32'h0);
    check_eq("rec0_pc",   trace_pc,   TRACE_EN ? 32'h400 : 32'h0);
    @(negedge clk);
    drive(BASE + 8, 0, 0, 0, 1); step();
    check_eq("rec1_data", trace_data, TRACE_EN ? 32'h12BB_5678 : 32'h0);
    check_eq("rec1_pc",   trace_pc,   TRACE_EN ? 32'h404 : 32'h0);
    repeat (2) step();

    // Out-of-range writes above the top and below BASE
    drive(BASE + 32'(NW * 4), 32'hFFFF_FFFF, 4'b1111, 32'h500, 1); step();
    check_eq("oor_set", oor_err, 1);
    drive(BASE - 4, 32'hFFFF_FFFF, 4'b1111, 32'h504, 1); step();
    drive(BASE + 32'(NW * 4), 0, 0, 0, 1); step();
    drive(BASE + 8, 0, 0, 0, 1); step();

    // Overflow: ten stores with the logger stalled
    for (int i = 0; i < 10; i++) begin
      drive(BASE + 32'(4 * (i % NW)), $urandom, 4'b1111, 32'h600 + 32'(4 * i), 0);
      step();
    end
    check_eq("drop_10", trace_drop, TRACE_EN ? 2 : 0);
    drive(BASE + 4, $urandom, 4'b0011, 32'h700, 1); step();
    check_eq("full_pushpop_drop", trace_drop, TRACE_EN ? 2 : 0);
    check_eq("full_pushpop_occ", q.size(), TRACE_EN ? 8 : 0);
    for (int i = 0; i < 10; i++) begin
      drive(BASE + 32'(4 * i), 0, 0, 0, 1);
      step();
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0)
        a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : BASE + 64 + 32'($urandom_range(0, 999));
      else
        a = BASE + 32'(4 * $urandom_range(0, NW - 1)) + 32'($urandom_range(0, 3));
      drive(a, $urandom, 4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 99) < 40);
      step();
    end

    // Reset with a populated FIFO, then again mid-sweep
    for (int i = 0; i < 5; i++) begin
      drive(BASE + 8, $urandom, 4'b1111, 32'h800 + 32'(i), 0);
      step();
    end
    #2 reset = 1'b0;
    #1 check_reset_vals("rst_fifo");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1 check_reset_vals("rst_sweep");
    @(negedge clk);
    reset = 1'b1;
    wait_init();
    for (int i = 0; i < NW; i++) begin
      drive(BASE + 32'(4 * i), 0, 0, 0, 1);
      step();
    end
    drive(BASE + 12, 32'hCAFE_F00D, 4'b1000, 32'h900, 1); step();
    drive(BASE + 12, 0, 0, 0, 1); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
